// File: rtl/bht_counter_table_if.sv
// Prediction/update/flush bundle for bht_counter_table; the fetch/EX side is master,
// the table is slave.
interface bht_counter_table_if #(
  parameter int IDXW = 6
);
  logic [31:0]     pred_pc;
  logic            pred_taken;
  logic            pred_strong;
  logic [IDXW-1:0] pred_idx;
  logic            upd_valid;
  logic [IDXW-1:0] upd_idx;
  logic            upd_taken;
  logic            flush;

  modport master (
    output pred_pc, upd_valid, upd_idx, upd_taken, flush,
    input  pred_taken, pred_strong, pred_idx
  );

  modport slave (
    input  pred_pc, upd_valid, upd_idx, upd_taken, flush,
    output pred_taken, pred_strong, pred_idx
  );
endinterface

// File: rtl/bht_counter_table.sv
// Branch history table of saturating counters with same-cycle update forwarding and flush.
// Optional gshare indexing with a global history register is enabled by BHT_GSHARE_EN.
module bht_counter_table #(
  parameter int WIDTH    = 2,
  parameter int ENTRIES  = 64,
  parameter int IDX_LSB  = 2,
  parameter int INIT     = 2**(WIDTH-1)-1,
  parameter int GHR_BITS = 6
) (
  input  logic                clk,
  input  logic                reset_n,
  bht_counter_table_if.slave  bus
);
  localparam int IDXW = $clog2(ENTRIES);
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] MAX_V  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_V  = {WIDTH{1'b0}};

  logic [WIDTH-1:0] ctr_r [ENTRIES];
  logic [IDXW-1:0]  pred_idx_s;
  logic             upd_acc_s;
  logic [WIDTH-1:0] upd_next_s;
  logic [WIDTH-1:0] sel_s;
  logic             unused_pc_s;

  // Saturating step: never wraps at either end.
  function automatic logic [WIDTH-1:0] sat_next(input logic [WIDTH-1:0] c, input logic taken);
    logic [WIDTH-1:0] n;
    if (taken) begin
      n = (c == MAX_V) ? c : c + WIDTH'(1);
    end else begin
      n = (c == MIN_V) ? c : c - WIDTH'(1);
    end
    return n;
  endfunction

  assign unused_pc_s = ^bus.pred_pc;

`ifdef BHT_GSHARE_EN
  logic [GHR_BITS-1:0] ghr_r;

  // Non-speculative global history, shifted on every accepted update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ghr_r <= {GHR_BITS{1'b0}};
    end else if (bus.flush) begin
      ghr_r <= {GHR_BITS{1'b0}};
    end else if (bus.upd_valid) begin
      ghr_r <= {ghr_r[GHR_BITS-2:0], bus.upd_taken};
    end
  end

  // Index hashes PC bits with the zero-extended history.
  always_comb begin
    pred_idx_s = bus.pred_pc[IDX_LSB +: IDXW] ^ IDXW'(ghr_r);
  end
`else
  // Index is taken straight from the PC.
  always_comb begin
    pred_idx_s = bus.pred_pc[IDX_LSB +: IDXW];
  end
`endif

  // Reset in progress also suppresses forwarding, since that update will be discarded.
  always_comb begin
    upd_acc_s  = bus.upd_valid && !bus.flush && reset_n;
    upd_next_s = sat_next(ctr_r[bus.upd_idx], bus.upd_taken);
    if (upd_acc_s && (bus.upd_idx == pred_idx_s)) begin
      sel_s = upd_next_s;
    end else begin
      sel_s = ctr_r[pred_idx_s];
    end
  end

  // Prediction outputs derive from the selected (possibly forwarded) counter.
  always_comb begin
    bus.pred_idx    = pred_idx_s;
    bus.pred_taken  = sel_s[WIDTH-1];
    bus.pred_strong = (sel_s == MAX_V) || (sel_s == MIN_V);
  end

  // Counter table: flush beats update, reset beats both.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_r[i] <= INIT_V;
      end
    end else if (bus.flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_r[i] <= INIT_V;
      end
    end else if (bus.upd_valid) begin
      ctr_r[bus.upd_idx] <= upd_next_s;
    end
  end
endmodule

// File: tb/tb_bht_counter_table.sv
// Self-checking bench for bht_counter_table: integer model compared every cycle
// plus hand-computed expectations from the directed test plan.
module tb_bht_counter_table;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  bht_counter_table_if #(.IDXW(6)) bus ();
  bht_counter_table dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  int m_ctr [64];
  int m_ghr;
  bit cmp_en = 1'b0;

`ifdef BHT_GSHARE_EN
  localparam bit PLAIN = 1'b0;
`else
  localparam bit PLAIN = 1'b1;
`endif

  function automatic int sat(int v, bit t);
    if (t) return (v >= 3) ? 3 : v + 1;
    else   return (v <= 0) ? 0 : v - 1;
  endfunction

  // Reference table state, counters held as plain integers 0..3.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) m_ctr[i] <= 1;
      m_ghr <= 0;
    end else if (bus.flush) begin
      for (int i = 0; i < 64; i++) m_ctr[i] <= 1;
      m_ghr <= 0;
    end else if (bus.upd_valid) begin
      m_ctr[bus.upd_idx] <= sat(m_ctr[bus.upd_idx], bus.upd_taken);
`ifdef BHT_GSHARE_EN
      m_ghr <= ((m_ghr * 2) + int'(bus.upd_taken)) % 64;
`endif
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    int idx;
    int v;
    idx = int'((bus.pred_pc / 32'd4) % 32'd64) ^ m_ghr;
    v = m_ctr[idx];
    if (reset_n && bus.upd_valid && !bus.flush && int'(bus.upd_idx) == idx)
      v = sat(v, bus.upd_taken);
    chk("model_idx", 32'(bus.pred_idx), 32'(idx));
    chk("model_taken", 32'(bus.pred_taken), (v >= 2) ? 32'd1 : 32'd0);
    chk("model_strong", 32'(bus.pred_strong), (v == 0 || v == 3) ? 32'd1 : 32'd0);
  endtask

  // Every negedge the outputs are compared against the model.
  always @(negedge clk) begin
    if (cmp_en) compare_model();
  end

  task automatic lit(string name, bit t, bit s);
    chk({name, "_taken"}, 32'(bus.pred_taken), 32'(t));
    chk({name, "_strong"}, 32'(bus.pred_strong), 32'(s));
  endtask

  // Inputs change just after posedge; caller observes at the following negedge.
  task automatic drive(logic [31:0] pc, bit uv, int ui, bit ut, bit fl);
    @(posedge clk);
    #1;
    bus.pred_pc   = pc;
    bus.upd_valid = uv;
    bus.upd_idx   = 6'(ui);
    bus.upd_taken = ut;
    bus.flush     = fl;
    @(negedge clk);
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.pred_pc   = 32'd0;
    bus.upd_valid = 1'b0;
    bus.upd_idx   = 6'd0;
    bus.upd_taken = 1'b0;
    bus.flush     = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    cmp_en = 1'b1;

    // Reset sweep: every index reads weakly not-taken.
    for (int i = 0; i < 64; i++) begin
      drive(32'(i * 4), 1'b0, 0, 1'b0, 1'b0);
      lit("reset_sweep", 1'b0, 1'b0);
      chk("reset_idx", 32'(bus.pred_idx), 32'(i));
    end

    if (PLAIN) begin
      // Saturation upward on idx 5, then one step down.
      drive(32'h14, 1'b1, 5, 1'b1, 1'b0);
      drive(32'h14, 1'b0, 0, 1'b0, 1'b0); lit("up_2", 1'b1, 1'b0);
      drive(32'h14, 1'b1, 5, 1'b1, 1'b0);
      drive(32'h14, 1'b0, 0, 1'b0, 1'b0); lit("up_3", 1'b1, 1'b1);
      drive(32'h14, 1'b1, 5, 1'b1, 1'b0);
      drive(32'h14, 1'b0, 0, 1'b0, 1'b0); lit("hold_3", 1'b1, 1'b1);
      drive(32'h14, 1'b1, 5, 1'b0, 1'b0);
      drive(32'h14, 1'b0, 0, 1'b0, 1'b0); lit("down_2", 1'b1, 1'b0);

      // Saturation downward on idx 9, plus aliasing.
      for (int k = 0; k < 3; k++) drive(32'h0, 1'b1, 9, 1'b0, 1'b0);
      drive(32'h24, 1'b0, 0, 1'b0, 1'b0);  lit("sat_0", 1'b0, 1'b1);
      drive(32'h124, 1'b0, 0, 1'b0, 1'b0); lit("alias", 1'b0, 1'b1);
      chk("alias_idx", 32'(bus.pred_idx), 32'd9);

      // Forwarding: idx 5 back at 1 after a flush.
      drive(32'h0, 1'b0, 0, 1'b0, 1'b1);
      drive(32'h14, 1'b1, 5, 1'b1, 1'b0); lit("fwd_hit", 1'b1, 1'b0);
      drive(32'h18, 1'b1, 5, 1'b1, 1'b0); lit("fwd_miss", 1'b0, 1'b0);

      // Flush with a simultaneous update to idx 5 (counter 3): stored value, update lost.
      drive(32'h14, 1'b1, 5, 1'b0, 1'b1); lit("flush_nofwd", 1'b1, 1'b1);
      drive(32'h14, 1'b0, 0, 1'b0, 1'b0); lit("flush_idx5", 1'b0, 1'b0);
      drive(32'h24, 1'b0, 0, 1'b0, 1'b0); lit("flush_idx9", 1'b0, 1'b0);

      // Asynchronous reset in the middle of an update.
      drive(32'h14, 1'b1, 5, 1'b1, 1'b0);
      drive(32'h14, 1'b1, 5, 1'b1, 1'b0);
      drive(32'h14, 1'b1, 5, 1'b1, 1'b0); lit("pre_reset", 1'b1, 1'b1);
      cmp_en = 1'b0;
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1 lit("async_reset", 1'b0, 1'b0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      bus.upd_valid = 1'b0;
      @(negedge clk);
      lit("post_reset", 1'b0, 1'b0);
      cmp_en = 1'b1;
    end

`ifdef BHT_GSHARE_EN
    // History taken, taken, not-taken gives ghr 6; pc 0x14 hashes to idx 3.
    drive(32'h0, 1'b0, 0, 1'b0, 1'b1);
    drive(32'h0, 1'b1, 0, 1'b1, 1'b0);
    drive(32'h0, 1'b1, 0, 1'b1, 1'b0);
    drive(32'h0, 1'b1, 0, 1'b0, 1'b0);
    drive(32'h14, 1'b0, 0, 1'b0, 1'b0);
    chk("gshare_idx", 32'(bus.pred_idx), 32'd3);
    lit("gshare_pred", 1'b0, 1'b0);
`endif

    drive(32'h0, 1'b0, 0, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
